alu_seq: RTL and testbench

Sequential command front-end for the combinational `alu` block. It accepts one operation at a time over a valid/ready command port and drives the ALU's `sel`/`op1`/`op2` inputs from registers. It captures the ALU's result and zero/negative flags, then presents them on a valid/ready result port. It sits between a requester (bench, future decode/control logic) and an `alu` instance, and optionally keeps an accumulator so chained operations can reuse the previous result.

---
 rtl/alu_seq.sv | 121 ++++++++++++
 tb/tb_alu_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Valid/ready command front-end that registers ALU operands, captures the ALU result and flags,
// and presents them on a result handshake. Optional accumulator enabled by ALU_SEQ_ACC_EN.
module alu_seq #(
    parameter int DWIDTH = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_sel_i,
    input  logic [DWIDTH-1:0] cmd_op1_i,
    input  logic [DWIDTH-1:0] cmd_op2_i,
    input  logic              cmd_acc_i,
    output logic [1:0]        alu_sel_o,
    output logic [DWIDTH-1:0] alu_op1_o,
    output logic [DWIDTH-1:0] alu_op2_o,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic              alu_zero_i,
    input  logic              alu_neg_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DWIDTH-1:0] res_data_o,
    output logic              res_zero_o,
    output logic              res_neg_o,
    output logic [CNTW-1:0]   op_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              capture;
    logic              handshake;
    logic [DWIDTH-1:0] op1_sel;

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        handshake   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready_i) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALU_SEQ_ACC_EN
    logic [DWIDTH-1:0] acc_q;

    // Accumulator tracks the most recent ALU result so chained ops can reuse it as op1.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (capture) begin
            acc_q <= alu_res_i;
        end
    end

    assign op1_sel = cmd_acc_i ? acc_q : cmd_op1_i;
`else
    logic acc_unused;
    assign acc_unused = cmd_acc_i;
    assign op1_sel    = cmd_op1_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            alu_sel_o   <= '0;
            alu_op1_o   <= '0;
            alu_op2_o   <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_zero_o  <= 1'b0;
            res_neg_o   <= 1'b0;
            op_cnt_o    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_sel_o <= cmd_sel_i;
                alu_op1_o <= op1_sel;
                alu_op2_o <= cmd_op2_i;
            end
            // Flags are passed through exactly as the ALU reported them.
            if (capture) begin
                res_data_o  <= alu_res_i;
                res_zero_o  <= alu_zero_i;
                res_neg_o   <= alu_neg_i;
                res_valid_o <= 1'b1;
            end
            if (handshake) begin
                res_valid_o <= 1'b0;
                op_cnt_o    <= op_cnt_o + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with an 8-bit combinational ALU stand-in; honours ALU_SEQ_ACC_EN.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_sel = '0;
    logic [7:0] cmd_op1 = '0;
    logic [7:0] cmd_op2 = '0;
    logic       cmd_acc = 1'b0;
    logic [1:0] alu_sel;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [7:0] alu_res;
    logic       alu_zero;
    logic       alu_neg;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       res_zero;
    logic       res_neg;
    logic [7:0] op_cnt;

    alu_seq #(.DWIDTH(8), .CNTW(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_sel_i   (cmd_sel),
        .cmd_op1_i   (cmd_op1),
        .cmd_op2_i   (cmd_op2),
        .cmd_acc_i   (cmd_acc),
        .alu_sel_o   (alu_sel),
        .alu_op1_o   (alu_op1),
        .alu_op2_o   (alu_op2),
        .alu_res_i   (alu_res),
        .alu_zero_i  (alu_zero),
        .alu_neg_i   (alu_neg),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_zero_o  (res_zero),
        .res_neg_o   (res_neg),
        .op_cnt_o    (op_cnt)
    );

    // Combinational ALU attached to the block
    always_comb begin
        case (alu_sel)
            2'd0:    alu_res = alu_op1 + alu_op2;
            2'd1:    alu_res = alu_op1 - alu_op2;
            2'd2:    alu_res = alu_op1 & alu_op2;
            default: alu_res = alu_op1 | alu_op2;
        endcase
    end
    assign alu_zero = (alu_res == 8'h00);
    assign alu_neg  = alu_res[7];

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       zero;
        logic       neg;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         rdy_mode = 0;
    bit         done = 1'b0;
    bit         busy = 1'b0;
    int         lat = 0;
    bit         was_rst = 1'b0;
    logic [7:0] cnt_model = '0;
    logic [7:0] acc_model = '0;
    logic [1:0] exp_sel = '0;
    logic [7:0] exp_op1 = '0;
    logic [7:0] exp_op2 = '0;

    function automatic int model_alu(input int s, input int a, input int b);
        int r;
        case (s)
            0:       r = a + b;
            1:       r = a - b + 256;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r % 256;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: sampled on the falling edge
    always @(negedge clk) begin
        if (done) begin
            chk("drain_empty", sb_q.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (!rst_ni) begin
            sb_q.delete();
            busy      = 1'b0;
            lat       = 0;
            cnt_model = '0;
            acc_model = '0;
            was_rst   = 1'b1;
        end else begin
            if (was_rst) begin
                chk("rst_res_data", res_data, 8'h00);
                chk("rst_res_zero", res_zero, 1'b0);
                chk("rst_res_neg", res_neg, 1'b0);
                chk("rst_alu_sel", alu_sel, 2'd0);
                chk("rst_alu_op1", alu_op1, 8'h00);
                chk("rst_alu_op2", alu_op2, 8'h00);
                was_rst = 1'b0;
            end
            chk("cmd_ready", cmd_ready, !busy);
            chk("res_valid", res_valid, busy && lat == 0);
            chk("op_cnt", op_cnt, cnt_model);
            if (busy && lat == 1) begin
                chk("alu_sel", alu_sel, exp_sel);
                chk("alu_op1", alu_op1, exp_op1);
                chk("alu_op2", alu_op2, exp_op2);
            end
            if (res_valid) begin
                if (sb_q.size() == 0) begin
                    chk("result_without_cmd", 1, 0);
                end else begin
                    chk("res_data", res_data, sb_q[0].data);
                    chk("res_zero", res_zero, sb_q[0].zero);
                    chk("res_neg", res_neg, sb_q[0].neg);
                    if (res_ready) begin
                        void'(sb_q.pop_front());
                        cnt_model = cnt_model + 8'd1;
                        busy      = 1'b0;
                    end
                end
            end
            if (busy && lat > 0) lat--;
            if (cmd_valid && cmd_ready) begin
                int   a;
                int   r;
                exp_t e;
`ifdef ALU_SEQ_ACC_EN
                a = cmd_acc ? int'(acc_model) : int'(cmd_op1);
`else
                a = int'(cmd_op1);
`endif
                r         = model_alu(int'(cmd_sel), a, int'(cmd_op2));
                e.data    = 8'(r);
                e.zero    = (r == 0);
                e.neg     = (r >= 128);
                sb_q.push_back(e);
                acc_model = 8'(r);
                exp_sel   = cmd_sel;
                exp_op1   = 8'(a);
                exp_op2   = cmd_op2;
                busy      = 1'b1;
                lat       = 1;
            end
        end
    end

    // Result-side ready generator
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'b0;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b, input logic acc);
        bit taken;
        taken     = 1'b0;
        cmd_sel   = s;
        cmd_op1   = a;
        cmd_op2   = b;
        cmd_acc   = acc;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100 && !taken; n++) begin
            @(negedge clk);
            if (cmd_ready) taken = 1'b1;
        end
        if (!taken) begin
            $display("FAIL cmd_accept_timeout: got no accept expected accept within 100 cycles");
            $fatal(1);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_sel   = 2'($urandom);
        cmd_op1   = 8'($urandom);
        cmd_op2   = 8'($urandom);
        cmd_acc   = 1'($urandom);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        if (!seen) begin
            $display("FAIL res_valid_timeout: got no result expected result within 50 cycles");
            $fatal(1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        send(2'd0, 8'h05, 8'h03, 1'b0);
        send(2'd1, 8'h03, 8'h05, 1'b0);
        send(2'd2, 8'hF0, 8'h0F, 1'b0);
        send(2'd3, 8'hF0, 8'h0F, 1'b0);

        // Backpressure: result held for several cycles while a second command waits
        wait_valid();
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send(2'd0, 8'h7F, 8'h01, 1'b0);
        fork
            begin
                repeat (6) @(posedge clk);
                rdy_mode = 0;
            end
        join_none
        send(2'd0, 8'h01, 8'h01, 1'b0);

        send(2'd0, 8'h10, 8'h01, 1'b0);
        send(2'd0, 8'hAA, 8'h02, 1'b1);

        // Reset while a result is held
        wait_valid();
        rdy_mode = 1;
        @(posedge clk);
        #2;
        send(2'd0, 8'h33, 8'h44, 1'b0);
        wait_valid();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni   = 1'b1;
        rdy_mode = 0;
        send(2'd0, 8'hAA, 8'h02, 1'b1);

        // Random traffic, long enough to wrap the operation counter
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
